// File: rtl/processor_run_controller_if.sv
// ============================================================================
// Module      : processor_run_controller_if
// Description : Run-control bundle between a host/stimulus side and the
//               processor_run_controller.
//                 start, halt_req          : run request / early stop
//                 cpu_reset, cpu_en        : reset and clock-enable to processor
//                 busy, done, cycle_count  : run status
//               master modport drives requests, slave modport (the
//               controller) drives processor controls and status.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface processor_run_controller_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             halt_req;
    logic             cpu_reset;
    logic             cpu_en;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output start,
        output halt_req,
        input  cpu_reset,
        input  cpu_en,
        input  busy,
        input  done,
        input  cycle_count
    );

    modport slave (
        input  start,
        input  halt_req,
        output cpu_reset,
        output cpu_en,
        output busy,
        output done,
        output cycle_count
    );
endinterface

`default_nettype wire

// File: rtl/processor_run_controller.sv
// ============================================================================
// Module      : processor_run_controller
// Description : Run sequencer for the MIPS processor. Owns the processor reset
//               and clock-enable: a run holds cpu_reset for RESET_CYCLES
//               cycles, then enables the processor for up to MAX_CYCLES
//               cycles (or until halt_req), then parks it in DONE for
//               inspection.
//   Ports     : clk         - system clock, rising edge
//               reset       - asynchronous, active-low reset
//               bus (slave) - start, halt_req in;
//                             cpu_reset, cpu_en, busy, done, cycle_count out
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module processor_run_controller #(
    parameter int RESET_CYCLES = 2,
    parameter int MAX_CYCLES   = 25,
    parameter int CNT_W        = 16
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    processor_run_controller_if.slave  bus
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_HOLD = 2'd1;
    localparam logic [1:0] c_ST_RUN  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    // Hold counter only needs to reach RESET_CYCLES-1.
    localparam int                    c_HOLD_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [c_HOLD_W-1:0]   c_HOLD_LAST = c_HOLD_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]      c_MAX       = CNT_W'(MAX_CYCLES);

    logic [1:0]          r_state;
    logic [c_HOLD_W-1:0] r_hold;
    logic [CNT_W-1:0]    r_count;
    logic                r_cpu_reset;
    logic                r_cpu_en;
    logic                r_busy;
    logic                r_done;

    logic [1:0]          w_state_nxt;
    logic [c_HOLD_W-1:0] w_hold_nxt;
    logic [CNT_W-1:0]    w_count_nxt;
    logic [CNT_W-1:0]    w_count_inc;

    assign w_count_inc = r_count + CNT_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_count_nxt = r_count;
        case (r_state)
            c_ST_IDLE, c_ST_DONE: begin
                if (bus.start) begin
                    w_state_nxt = c_ST_HOLD;
                    w_hold_nxt  = '0;
                    w_count_nxt = '0;
                end
            end
            c_ST_HOLD: begin
                if (r_hold == c_HOLD_LAST) begin
                    w_state_nxt = c_ST_RUN;
                    w_hold_nxt  = '0;
                end else begin
                    w_hold_nxt  = r_hold + c_HOLD_W'(1);
                end
            end
            c_ST_RUN: begin
                // Every RUN edge is an enabled processor cycle, including the
                // one that samples halt_req; halt simply ends the run early.
                w_count_nxt = w_count_inc;
                if ((w_count_inc == c_MAX) || bus.halt_req) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register together with
    // it; the asynchronous reset loads the IDLE output values directly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_ST_IDLE;
            r_hold      <= '0;
            r_count     <= '0;
            r_cpu_reset <= 1'b1;
            r_cpu_en    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold      <= w_hold_nxt;
            r_count     <= w_count_nxt;
            r_cpu_reset <= (w_state_nxt == c_ST_IDLE) || (w_state_nxt == c_ST_HOLD);
            r_cpu_en    <= (w_state_nxt == c_ST_RUN);
            r_busy      <= (w_state_nxt == c_ST_HOLD) || (w_state_nxt == c_ST_RUN);
            r_done      <= (w_state_nxt == c_ST_DONE);
        end
    end

    assign bus.cpu_reset   = r_cpu_reset;
    assign bus.cpu_en      = r_cpu_en;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.cycle_count = r_count;

endmodule

`default_nettype wire

// File: doc/processor_run_controller.md
# processor_run_controller

- Synthesizable on-chip run sequencer for the MIPS `processor`.
- Owns the processor's reset and clock-enable so that a bounded run no longer needs a hand-toggled clock sequence. A run is a hold-reset phase followed by a counted execution window.
- It sits between the board-level `clk`/`reset` and `processor`, and reports completion and the executed cycle count.

## Interface

Parameters:

- RESET_CYCLES, 2: cycles `cpu_reset` is held high after a start; legal range ≥1.
- MAX_CYCLES, 25: maximum enabled processor cycles per run; legal range 1 to 2^CNT_W−1.
- CNT_W, 16: width of `cycle_count`.

Ports:

- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  run request, sampled per cycle.
- halt_req  input  1  early-stop request, honoured only in RUN.
- cpu_reset  output  1  active-high reset to `processor`.
- cpu_en  output  1  clock-enable to `processor`.
- busy  output  1  high in RESET_HOLD and RUN.
- done  output  1  level, high in DONE.
- cycle_count  output  CNT_W  number of enabled cycles in the current or last run.

## Operation

- States: IDLE, RESET_HOLD, RUN, DONE. All outputs are registered and decoded from state and counters.
- Output values per state:
  - IDLE: cpu_reset=1, cpu_en=0, busy=0, done=0.
  - RESET_HOLD: cpu_reset=1, cpu_en=0, busy=1, done=0.
  - RUN: cpu_reset=0, cpu_en=1, busy=1, done=0.
  - DONE: cpu_reset=0, cpu_en=0, busy=0, done=1. The processor is held for state inspection.
- Reset (reset=0, asynchronous): state=IDLE, hold counter=0, cycle_count=0. Outputs take their IDLE values immediately, without waiting for a clock edge.
- IDLE: start=1 → RESET_HOLD; hold counter and cycle_count are cleared.
- RESET_HOLD: the hold counter increments each cycle. After RESET_CYCLES cycles in this state → RUN. start and halt_req are ignored.
- RUN:
  - cycle_count increments by 1 on every edge where cpu_en=1.
  - Leave for DONE when the incremented count equals MAX_CYCLES, or when halt_req=1. The cycle in which halt_req is sampled counts.
  - start is ignored.
- DONE: cycle_count is frozen. start=1 → RESET_HOLD, which clears cycle_count and begins a new run. halt_req is ignored.
- Simultaneous events in RUN:
  - halt_req=1 on the same edge the count reaches MAX_CYCLES → DONE, cycle_count=MAX_CYCLES.
  - start with halt_req → halt wins; start is not queued.
- cycle_count never exceeds MAX_CYCLES and never wraps.
- Reset deassertion mid-run: the block always restarts in IDLE; no partial run resumes.

## Timing

- start sampled high at edge t (from IDLE or DONE):
  - cpu_reset=1, busy=1 from edge t+1.
  - cpu_en=1, cpu_reset=0 at edge t+1+RESET_CYCLES.
- Full run: done=1 at edge t+1+RESET_CYCLES+MAX_CYCLES. cpu_en is high for exactly MAX_CYCLES cycles.
- halt_req sampled high at RUN edge h: cpu_en=0, done=1 from edge h+1. cycle_count includes edge h.
- cpu_en and cpu_reset are never both 1.
- Reset assertion forces cpu_reset=1 and cpu_en=0 combinationally (asynchronously), regardless of clock.
- Release of reset is synchronised by the first clock edge; start on that first edge is accepted.

## Test plan

- Reset, then start pulse at cycle 5 with defaults:
  - cpu_reset high for cycles 6–7.
  - cpu_en high for cycles 8–32.
  - done=1 at cycle 33 with cycle_count=25.
  - busy is its complement throughout.
- Default run with halt_req pulsed at the 10th enabled cycle → done one cycle later, cycle_count=10, cpu_en low thereafter.
- halt_req on the same cycle as the 25th enabled cycle → cycle_count=25 (not 26), single transition to DONE.
- start held high continuously through a run → no restart while busy. A new RESET_HOLD begins the cycle after done, and cycle_count reads 0 on entry.
- Reset driven low mid-RUN at cycle_count=12, between clock edges:
  - cpu_reset=1, cpu_en=0, cycle_count=0 immediately.
  - IDLE after release; no done pulse.
- Parameter sweep RESET_CYCLES=1 / MAX_CYCLES=1, and MAX_CYCLES=2^CNT_W−1 with CNT_W=4 → exact hold/run lengths, no counter wrap.
